// File: rtl/user_rdwr_reg.sv
// User data register behind a TAP-style Capture/Shift/Update protocol.
// Only sequences that start with a CAPTURE can update PO; shifting while idle
// simply passes data through SR (bypass-like) without arming an update.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no sequence in progress; UPDATE is ignored, SHIFT bypasses
//   ARMED    | SR captured, no bits shifted yet (BC = 0)
//   SHIFTING | at least one bit shifted since the capture
module user_rdwr_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] DEF_VALUE = '0,
  parameter bit               CHECK_LEN = 1'b1
) (
  input  logic             TCK,
  input  logic             RST,
  input  logic             SEL,
  input  logic             FSEL,
  input  logic             CAPTURE,
  input  logic             SHIFT,
  input  logic             UPDATE,
  input  logic             TDI,
  input  logic             RD_MODE,
  input  logic [WIDTH-1:0] PI,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] PO,
  output logic             TDO,
  output logic             UPD_STB,
  output logic             LEN_ERR,
  output logic [7:0]       UPD_CNT
);

  // BC must be able to hold WIDTH+1 so over-length shifts stay distinguishable
  localparam int           BW      = $clog2(WIDTH + 2);
  localparam logic [BW-1:0] BC_FULL = BW'(WIDTH);
  localparam logic [BW-1:0] BC_MAX  = BW'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SHIFTING = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] po_nxt;
  logic [BW-1:0]    bc, bc_nxt;
  logic [7:0]       cnt_nxt;
  logic             stb_nxt;
  logic             set_err;
  logic             err_nxt;
  logic             act;
  logic             len_ok;

  assign act    = SEL & FSEL;
  assign len_ok = CHECK_LEN ? (bc == BC_FULL) : (bc != '0);
  assign TDO    = FSEL & sr[0];

  // State register
  always_ff @(posedge TCK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath registers: shift register, bit counter, outputs and status
  always_ff @(posedge TCK) begin
    if (RST) begin
      sr      <= DEF_VALUE;
      bc      <= '0;
      PO      <= DEF_VALUE;
      UPD_STB <= 1'b0;
      LEN_ERR <= 1'b0;
      UPD_CNT <= 8'd0;
    end else begin
      sr      <= sr_nxt;
      bc      <= bc_nxt;
      PO      <= po_nxt;
      UPD_STB <= stb_nxt;
      LEN_ERR <= err_nxt;
      UPD_CNT <= cnt_nxt;
    end
  end

  // Next-state and datapath decode; strobe priority CAPTURE > UPDATE > SHIFT
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    bc_nxt    = bc;
    po_nxt    = PO;
    stb_nxt   = 1'b0;
    cnt_nxt   = UPD_CNT;
    set_err   = 1'b0;

    if (act) begin
      if (CAPTURE) begin
        state_nxt = ARMED;
        sr_nxt    = RD_MODE ? PI : PO;
        bc_nxt    = '0;
      end else if (UPDATE) begin
        if (state != IDLE) begin
          state_nxt = IDLE;
          if (len_ok) begin
            po_nxt  = sr;
            stb_nxt = 1'b1;
            cnt_nxt = UPD_CNT + 8'd1;
          end else begin
            set_err = 1'b1;
          end
        end
      end else if (SHIFT) begin
        sr_nxt = {TDI, sr[WIDTH-1:1]};
        if (state != IDLE) begin
          state_nxt = SHIFTING;
          if (bc != BC_MAX) bc_nxt = bc + 1'b1;
        end
      end
    end

    // a new length error in the same cycle as a clear must remain visible
    err_nxt = set_err | (LEN_ERR & ~CLR_ERR);
  end

endmodule

// File: tb/tb_user_rdwr_reg.sv
// Scoreboard bench for user_rdwr_reg: two instances (length-checked and
// length-unchecked) share stimulus; a reference model predicts every update.
module tb_user_rdwr_reg;

  localparam logic [15:0] DEF = 16'h00A5;

  logic TCK = 1'b0;
  always #5 TCK = ~TCK;

  logic        rst = 1'b1, sel = 1'b1, fsel = 1'b1, capture = 1'b0, shift = 1'b0;
  logic        update = 1'b0, tdi = 1'b0, rd_mode = 1'b0, clr_err = 1'b0;
  logic [15:0] pi = 16'h0000;

  logic [15:0] po0, po1;
  logic        tdo0, tdo1, stb0, stb1, err0, err1;
  logic [7:0]  cnt0, cnt1;

  user_rdwr_reg #(.WIDTH(16), .DEF_VALUE(DEF), .CHECK_LEN(1'b0)) d0 (
    .TCK(TCK), .RST(rst), .SEL(sel), .FSEL(fsel), .CAPTURE(capture), .SHIFT(shift),
    .UPDATE(update), .TDI(tdi), .RD_MODE(rd_mode), .PI(pi), .CLR_ERR(clr_err),
    .PO(po0), .TDO(tdo0), .UPD_STB(stb0), .LEN_ERR(err0), .UPD_CNT(cnt0));

  user_rdwr_reg #(.WIDTH(16), .DEF_VALUE(DEF), .CHECK_LEN(1'b1)) d1 (
    .TCK(TCK), .RST(rst), .SEL(sel), .FSEL(fsel), .CAPTURE(capture), .SHIFT(shift),
    .UPDATE(update), .TDI(tdi), .RD_MODE(rd_mode), .PI(pi), .CLR_ERR(clr_err),
    .PO(po1), .TDO(tdo1), .UPD_STB(stb1), .LEN_ERR(err1), .UPD_CNT(cnt1));

  int tests = 0;
  int fails = 0;

  // reference model, index 0 = unchecked length, 1 = exact length required
  logic [15:0] m_sr[2];
  logic [15:0] m_po[2];
  logic        m_armed[2];
  int          m_n[2];
  logic        m_err[2];
  logic [7:0]  m_cnt[2];

  // expected {UPD_CNT, PO} for each accepted update
  logic [23:0] q0[$];
  logic [23:0] q1[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // advance the model by one clock using the inputs that were sampled
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic set_e;
      logic ok;
      set_e = 1'b0;
      if (rst) begin
        m_armed[k] = 1'b0;
        m_sr[k]    = DEF;
        m_po[k]    = DEF;
        m_n[k]     = 0;
        m_err[k]   = 1'b0;
        m_cnt[k]   = 8'd0;
      end else begin
        if (sel && fsel && capture) begin
          m_armed[k] = 1'b1;
          m_sr[k]    = rd_mode ? pi : m_po[k];
          m_n[k]     = 0;
        end else if (sel && fsel && update) begin
          if (m_armed[k]) begin
            m_armed[k] = 1'b0;
            ok = (k == 1) ? (m_n[k] == 16) : (m_n[k] >= 1);
            if (ok) begin
              m_po[k]  = m_sr[k];
              m_cnt[k] = m_cnt[k] + 8'd1;
              if (k == 0) q0.push_back({m_cnt[k], m_po[k]});
              else        q1.push_back({m_cnt[k], m_po[k]});
            end else begin
              set_e = 1'b1;
            end
          end
        end else if (sel && fsel && shift) begin
          m_sr[k] = {tdi, m_sr[k][15:1]};
          if (m_armed[k]) m_n[k]++;
        end
        m_err[k] = set_e ? 1'b1 : (clr_err ? 1'b0 : m_err[k]);
      end
    end
  endtask

  // one clock: apply the edge, update the model, compare visible state
  task automatic step();
    @(posedge TCK);
    #1;
    model_step();
    chk("po0", po0, m_po[0]);
    chk("po1", po1, m_po[1]);
    chk("len_err0", err0, m_err[0]);
    chk("len_err1", err1, m_err[1]);
    chk("upd_cnt0", cnt0, m_cnt[0]);
    chk("upd_cnt1", cnt1, m_cnt[1]);
    chk("tdo0", tdo0, fsel & m_sr[0][0]);
    chk("tdo1", tdo1, fsel & m_sr[1][0]);
  endtask

  // monitor: every strobe must match the oldest expected update
  always @(negedge TCK) begin
    logic [23:0] e;
    if (stb0 === 1'b1) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL stb0_spurious: got strobe expected none");
      end else begin
        e = q0.pop_front();
        chk("stb0_po", po0, e[15:0]);
        chk("stb0_cnt", cnt0, e[23:16]);
      end
    end else if (q0.size() != 0) begin
      e = q0.pop_front();
      tests++; fails++;
      $display("FAIL stb0_missing: got no strobe expected PO %0h", e[15:0]);
    end
    if (stb1 === 1'b1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL stb1_spurious: got strobe expected none");
      end else begin
        e = q1.pop_front();
        chk("stb1_po", po1, e[15:0]);
        chk("stb1_cnt", cnt1, e[23:16]);
      end
    end else if (q1.size() != 0) begin
      e = q1.pop_front();
      tests++; fails++;
      $display("FAIL stb1_missing: got no strobe expected PO %0h", e[15:0]);
    end
  end

  task automatic do_capture(input logic rd, input logic [15:0] p);
    rd_mode = rd; pi = p; capture = 1'b1;
    step();
    capture = 1'b0;
  endtask

  task automatic do_shift(input int n, input logic [31:0] data);
    for (int i = 0; i < n; i++) begin
      shift = 1'b1; tdi = data[i];
      step();
    end
    shift = 1'b0; tdi = 1'b0;
  endtask

  task automatic do_update();
    update = 1'b1;
    step();
    update = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] seq;
    logic [15:0] d;

    do_reset();
    chk("reset_po", po1, 16'h00A5);
    chk("reset_tdo", tdo1, 1'b1);
    chk("reset_cnt", cnt1, 8'd0);
    chk("reset_err", err1, 1'b0);

    // full-length write
    do_capture(1'b0, 16'h0000);
    do_shift(16, 32'h3C5A);
    do_update();
    step();
    chk("write_po", po1, 16'h3C5A);
    chk("write_cnt", cnt1, 8'd1);

    // readback of PI through TDO, then zeros land in PO
    do_capture(1'b1, 16'hBEEF);
    seq[0] = tdo1;
    for (int i = 1; i < 16; i++) begin
      do_shift(1, 32'h0);
      seq[i] = tdo1;
    end
    do_shift(1, 32'h0);
    chk("readback_seq", seq, 16'hBEEF);
    do_update();
    step();
    chk("readback_po", po1, 16'h0000);

    // under- and over-length shifts
    do_capture(1'b0, 16'h0);
    do_shift(15, 32'h7FFF);
    do_update();
    step();
    chk("short_err", err1, 1'b1);
    chk("short_po", po1, 16'h0000);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("clr_err", err1, 1'b0);
    do_capture(1'b0, 16'h0);
    do_shift(17, 32'h1FFFF);
    do_update();
    step();
    chk("long_err", err1, 1'b1);

    // set wins over same-cycle clear
    do_capture(1'b0, 16'h0);
    do_shift(3, 32'h5);
    clr_err = 1'b1;
    do_update();
    clr_err = 1'b0;
    chk("set_wins", err1, 1'b1);
    clr_err = 1'b1; step(); clr_err = 1'b0;

    // unchecked-length instance: zero PO then 4-bit write
    do_capture(1'b1, 16'h0000);
    do_shift(16, 32'h0);
    do_update();
    do_capture(1'b0, 16'h0);
    do_shift(4, 32'hB);
    do_update();
    step();
    chk("short_ok_po0", po0, 16'hB000);

    // act dropped mid-sequence
    d = 16'hA1C7;
    do_capture(1'b0, 16'h0);
    do_shift(8, {16'h0, d});
    fsel = 1'b0; shift = 1'b1; tdi = 1'b1; update = 1'b1;
    for (int i = 0; i < 3; i++) step();
    fsel = 1'b1; shift = 1'b0; update = 1'b0;
    do_shift(8, {24'h0, d[15:8]});
    do_update();
    step();
    chk("pause_po", po1, 16'hA1C7);

    // reset mid-shift aborts; later UPDATE is ignored
    do_capture(1'b0, 16'h0);
    do_shift(5, 32'h1F);
    do_reset();
    do_shift(11, 32'h0);
    do_update();
    step();
    chk("abort_po", po1, DEF);
    chk("abort_cnt", cnt1, 8'd0);

    // counter wrap after 256 accepted updates
    for (int i = 0; i < 256; i++) begin
      do_capture(1'($urandom_range(0, 1)), 16'($urandom));
      do_shift(16, $urandom);
      do_update();
    end
    step();
    chk("wrap_cnt1", cnt1, 8'd0);
    chk("wrap_cnt0", cnt0, 8'd0);

    // random complete transactions with occasional length errors and pauses
    for (int t = 0; t < 120; t++) begin
      int n;
      n = int'($urandom_range(14, 18));
      do_capture(1'($urandom_range(0, 1)), 16'($urandom));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          sel = 1'($urandom_range(0, 1));
          fsel = ~sel;
          shift = 1'b1; tdi = 1'($urandom);
          step();
          sel = 1'b1; fsel = 1'b1;
        end
        do_shift(1, $urandom);
      end
      clr_err = ($urandom_range(0, 3) == 0);
      do_update();
      clr_err = 1'b0;
    end

    // unconstrained random strobes, including overlaps and rare resets
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      sel     = ($urandom_range(0, 9) != 0);
      fsel    = ($urandom_range(0, 9) != 0);
      capture = ($urandom_range(0, 19) == 0);
      update  = ($urandom_range(0, 14) == 0);
      shift   = ($urandom_range(0, 9) < 7);
      tdi     = 1'($urandom);
      rd_mode = 1'($urandom);
      pi      = 16'($urandom);
      clr_err = ($urandom_range(0, 19) == 0);
      step();
    end
    rst = 1'b0; sel = 1'b1; fsel = 1'b1; capture = 1'b0; update = 1'b0;
    shift = 1'b0; clr_err = 1'b0;
    step();
    step();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/user_rdwr_reg.md
USER_RDWR_REG -- requirements
Module: user_rdwr_reg

Interface
REQ-001 Parameter: WIDTH, 16, register length in bits (2..64).
REQ-002 Parameter: DEF_VALUE, 0, reset value of PO and the shift register.
REQ-003 Parameter: CHECK_LEN, 1; 1 = update only when exactly WIDTH bits were shifted, 0 = update when at least 1 bit was shifted.
REQ-004 TCK  in  1  sole clock; all state changes on rising TCK.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 SEL  in  1  user mode active.
REQ-007 FSEL  in  1  function select for this register.
REQ-008 CAPTURE  in  1  TAP Capture-DR state.
REQ-009 SHIFT  in  1  TAP Shift-DR state.
REQ-010 UPDATE  in  1  TAP Update-DR state.
REQ-011 TDI  in  1  serial data in.
REQ-012 RD_MODE  in  1  capture source select: 1 = PI, 0 = PO (write readback).
REQ-013 PI  in  WIDTH  parallel readback input.
REQ-014 CLR_ERR  in  1  clears LEN_ERR.
REQ-015 PO  out  WIDTH  registered parallel output.
REQ-016 TDO  out  1  serial out, combinational FSEL & SR[0].
REQ-017 UPD_STB  out  1  one-TCK pulse on each accepted update.
REQ-018 LEN_ERR  out  1  sticky length-error flag.
REQ-019 UPD_CNT  out  8  count of accepted updates, wraps 255 -> 0.

Function
REQ-020 Define act = SEL & FSEL; CAPTURE, SHIFT and UPDATE are ignored when act = 0.
REQ-021 FSM states: IDLE, ARMED, SHIFTING.
REQ-022 Priority among simultaneous strobes with act = 1: CAPTURE > UPDATE > SHIFT.
REQ-023 Any state, CAPTURE & act -> ARMED, SR <= (RD_MODE ? PI : PO), bit counter BC <= 0.
REQ-024 ARMED or SHIFTING, SHIFT & act -> SHIFTING, SR <= {TDI, SR[WIDTH-1:1]}, BC <= BC+1 saturating at WIDTH+1.
REQ-025 IDLE, SHIFT & act -> shift SR as in REQ-024, BC unchanged, state stays IDLE (bypass behaviour, no update possible).
REQ-026 ARMED or SHIFTING, UPDATE & act -> IDLE; accepted if (CHECK_LEN ? BC == WIDTH : BC >= 1).
REQ-027 Accepted update: PO <= SR next edge, UPD_STB = 1 for exactly that one cycle, UPD_CNT <= UPD_CNT+1.
REQ-028 Rejected update: PO, UPD_CNT unchanged, UPD_STB = 0, LEN_ERR <= 1.
REQ-029 UPDATE in IDLE: no effect on PO, UPD_STB, UPD_CNT or LEN_ERR.
REQ-030 act deasserted mid-sequence: state, SR and BC hold; resuming continues the sequence.
REQ-031 LEN_ERR: set per REQ-028, cleared by CLR_ERR; same-cycle set and clear -> set wins.
REQ-032 PO changes only on an accepted update or RST; TDO reflects SR[0] with zero latency.
REQ-033 Under/over-length shifts (BC < WIDTH or BC = WIDTH+1) with CHECK_LEN = 1 are rejected.

Reset
REQ-034 RST (sampled on rising TCK) overrides all inputs: state IDLE, SR = DEF_VALUE, PO = DEF_VALUE, BC = 0, UPD_STB = 0, LEN_ERR = 0, UPD_CNT = 0.
REQ-035 RST mid-shift aborts the sequence; a subsequent UPDATE without a new CAPTURE has no effect.

Verification (WIDTH = 16, DEF_VALUE = 16'h00A5, CHECK_LEN = 1 unless stated)
REQ-036 RST for 1 cycle -> PO = 16'h00A5, TDO = FSEL & 1, UPD_CNT = 0, LEN_ERR = 0.
REQ-037 CAPTURE, 16 SHIFTs of 16'h3C5A (LSB first), UPDATE -> PO = 16'h3C5A, UPD_STB high one cycle, UPD_CNT = 1.
REQ-038 RD_MODE = 1, PI = 16'hBEEF, CAPTURE, 16 SHIFTs with TDI = 0 -> TDO sequence is 16'hBEEF LSB first; the following UPDATE sets PO = 16'h0000.
REQ-039 CAPTURE, 15 SHIFTs, UPDATE -> PO unchanged, LEN_ERR = 1; then CLR_ERR -> LEN_ERR = 0; repeat with 17 SHIFTs -> LEN_ERR = 1.
REQ-040 CHECK_LEN = 0: CAPTURE, 4 SHIFTs of 4'b1011, UPDATE from PO = 16'h0000, RD_MODE = 0 -> PO = 16'hB000, UPD_STB pulses.
REQ-041 FSEL dropped for 3 cycles after 8 SHIFTs, then 8 more SHIFTs and UPDATE -> accepted; also 256 accepted updates -> UPD_CNT wraps to 0.
